// File: rtl/decode_execute_unit.sv
// RV32I decode + ALU + branch compare, registered for the memory/write-back stage.
// Optional: define DECODE_ILLEGAL_DET_EN to flag opcodes outside RV32I (and bad JALR funct3).
module decode_execute_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] instruction,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    output logic [4:0]  rf_rsel1,
    output logic [4:0]  rf_rsel2,
    output logic        out_valid,
    output logic [4:0]  rf_wsel,
    output logic        rf_wen,
    output logic        dm_wen,
    output logic [1:0]  rf_wdata_sel,
    output logic [31:0] alu_out,
    output logic        branch_taken,
    output logic        illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] WD_PC4  = 2'b00;
    localparam logic [1:0] WD_ALU  = 2'b01;
    localparam logic [1:0] WD_DM   = 2'b10;
    localparam logic [1:0] WD_NONE = 2'b11;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic [4:0] rd;

    assign opcode   = instruction[6:0];
    assign rd       = instruction[11:7];
    assign funct3   = instruction[14:12];
    assign f7b5     = instruction[30];
    assign rf_rsel1 = instruction[19:15];
    assign rf_rsel2 = instruction[24:20];

    logic unused_bits;
    assign unused_bits = ^{instruction[31], instruction[29:25]};

    // funct7[5] only matters for SUB (register form) and SRA/SRAI
    function automatic alu_op_t arith_op(input logic [2:0] f3,
                                         input logic alt,
                                         input logic reg_form);
        alu_op_t op;
        case (f3)
            3'b000:  op = (alt && reg_form) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    alu_op_t    alu_op;
    logic       op1_sel;
    logic       op2_sel;
    logic       rf_we;
    logic       dm_we;
    logic [1:0] wd_sel;
    logic       jump;
    logic       is_branch;
    logic       clear_lsb;
    logic       bad;

    always_comb begin
        alu_op    = ALU_ADD;
        op1_sel   = 1'b0;
        op2_sel   = 1'b1;
        rf_we     = 1'b0;
        dm_we     = 1'b0;
        wd_sel    = WD_NONE;
        jump      = 1'b0;
        is_branch = 1'b0;
        clear_lsb = 1'b0;
        bad       = 1'b0;
        case (opcode)
            OP_REG: begin
                op2_sel = 1'b0;
                rf_we   = 1'b1;
                wd_sel  = WD_ALU;
                alu_op  = arith_op(funct3, f7b5, 1'b1);
            end
            OP_IMM: begin
                rf_we  = 1'b1;
                wd_sel = WD_ALU;
                alu_op = arith_op(funct3, f7b5, 1'b0);
            end
            OP_LUI: begin
                rf_we  = 1'b1;
                wd_sel = WD_ALU;
                alu_op = ALU_PASSB;
            end
            OP_AUIPC: begin
                op1_sel = 1'b1;
                rf_we   = 1'b1;
                wd_sel  = WD_ALU;
            end
            OP_JAL: begin
                op1_sel = 1'b1;
                rf_we   = 1'b1;
                wd_sel  = WD_PC4;
                jump    = 1'b1;
            end
            OP_JALR: begin
                rf_we     = 1'b1;
                wd_sel    = WD_PC4;
                jump      = 1'b1;
                clear_lsb = 1'b1;
`ifdef DECODE_ILLEGAL_DET_EN
                bad       = (funct3 != 3'b000);
`endif
            end
            OP_BRANCH: begin
                op1_sel   = 1'b1;
                is_branch = 1'b1;
            end
            OP_LOAD: begin
                rf_we  = 1'b1;
                wd_sel = WD_DM;
            end
            OP_STORE: begin
                dm_we = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: begin
            end
            default: begin
`ifdef DECODE_ILLEGAL_DET_EN
                bad = 1'b1;
`endif
            end
        endcase
        if (bad) begin
            rf_we  = 1'b0;
            dm_we  = 1'b0;
            jump   = 1'b0;
            wd_sel = WD_NONE;
        end
    end

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] alu_raw;
    logic [31:0] alu_res;

    assign op_a  = op1_sel ? pc : rs1_data;
    assign op_b  = op2_sel ? imm : rs2_data;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_raw = op_a + op_b;
        case (alu_op)
            ALU_ADD:   alu_raw = op_a + op_b;
            ALU_SUB:   alu_raw = op_a - op_b;
            ALU_SLL:   alu_raw = op_a << shamt;
            ALU_SLT:   alu_raw = {31'b0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  alu_raw = {31'b0, op_a < op_b};
            ALU_XOR:   alu_raw = op_a ^ op_b;
            ALU_SRL:   alu_raw = op_a >> shamt;
            ALU_SRA:   alu_raw = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:    alu_raw = op_a | op_b;
            ALU_AND:   alu_raw = op_a & op_b;
            ALU_PASSB: alu_raw = op_b;
            default:   alu_raw = op_a + op_b;
        endcase
    end

    assign alu_res = clear_lsb ? {alu_raw[31:1], 1'b0} : alu_raw;

    logic eq;
    logic lt;
    logic ltu;
    logic cond;
    logic taken;

    assign eq  = (rs1_data == rs2_data);
    assign lt  = ($signed(rs1_data) < $signed(rs2_data));
    assign ltu = (rs1_data < rs2_data);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = eq;
            3'b001:  cond = !eq;
            3'b100:  cond = lt;
            3'b101:  cond = !lt;
            3'b110:  cond = ltu;
            3'b111:  cond = !ltu;
            default: cond = 1'b0;
        endcase
    end

    assign taken = jump | (is_branch & cond);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            rf_wen       <= 1'b0;
            dm_wen       <= 1'b0;
            branch_taken <= 1'b0;
            alu_out      <= 32'h0;
            rf_wsel      <= 5'd0;
            rf_wdata_sel <= WD_NONE;
        end else begin
            out_valid    <= in_valid;
            rf_wen       <= in_valid & rf_we & (rd != 5'd0);
            dm_wen       <= in_valid & dm_we;
            branch_taken <= in_valid & taken;
            if (in_valid) begin
                alu_out      <= alu_res;
                rf_wsel      <= rd;
                rf_wdata_sel <= wd_sel;
            end
        end
    end

`ifdef DECODE_ILLEGAL_DET_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal <= 1'b0;
        end else begin
            illegal <= in_valid & bad;
        end
    end
`else
    logic unused_bad;
    assign unused_bad = bad;
    assign illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_decode_execute_unit.sv
// Directed scoreboard bench for decode_execute_unit.
module tb_decode_execute_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rf_rsel1;
    logic [4:0]  rf_rsel2;
    logic        out_valid;
    logic [4:0]  rf_wsel;
    logic        rf_wen;
    logic        dm_wen;
    logic [1:0]  rf_wdata_sel;
    logic [31:0] alu_out;
    logic        branch_taken;
    logic        illegal;

    decode_execute_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .instruction(instruction), .pc(pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .rf_rsel1(rf_rsel1), .rf_rsel2(rf_rsel2),
        .out_valid(out_valid), .rf_wsel(rf_wsel),
        .rf_wen(rf_wen), .dm_wen(dm_wen),
        .rf_wdata_sel(rf_wdata_sel), .alu_out(alu_out),
        .branch_taken(branch_taken), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DECODE_ILLEGAL_DET_EN
    localparam bit ILL = 1'b1;
`else
    localparam bit ILL = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [4:0]  wsel;
        logic        rw;
        logic        dw;
        logic [1:0]  wds;
        logic [31:0] alu;
        logic        tk;
        logic        il;
        logic        chk_alu;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   tests = 0;
    int   fails = 0;

    function automatic logic [31:0] enc(input logic [6:0] f7,
                                        input logic [4:0] r2,
                                        input logic [4:0] r1,
                                        input logic [2:0] f3,
                                        input logic [4:0] rdv,
                                        input logic [6:0] op);
        return {f7, r2, r1, f3, rdv, op};
    endfunction

    function automatic exp_t mk(input bit v, input int ws, input bit rw,
                                input bit dw, input logic [1:0] wds,
                                input logic [31:0] alu, input bit tk,
                                input bit il, input bit ca);
        exp_t e;
        e.valid   = v;
        e.wsel    = 5'(ws);
        e.rw      = rw;
        e.dw      = dw;
        e.wds     = wds;
        e.alu     = alu;
        e.tk      = tk;
        e.il      = il;
        e.chk_alu = ca;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input string name, input logic v,
                        input logic [31:0] ins, input logic [31:0] pcv,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] im, input exp_t e);
        exp_t g;
        @(negedge clk);
        in_valid    = v;
        instruction = ins;
        pc          = pcv;
        rs1_data    = r1;
        rs2_data    = r2;
        imm         = im;
        q.push_back(e);
        #1;
        check({name, ".rsel1"}, 32'(rf_rsel1), 32'(ins[19:15]));
        check({name, ".rsel2"}, 32'(rf_rsel2), 32'(ins[24:20]));
        @(posedge clk);
        #1;
        tests++;
        assert (q.size() > 0) else begin
            fails++;
            $error("FAIL %s.queue observed=empty expected=entry", name);
        end
        if (q.size() > 0) begin
            g = q.pop_front();
            check({name, ".valid"}, 32'(out_valid), 32'(g.valid));
            check({name, ".wsel"}, 32'(rf_wsel), 32'(g.wsel));
            check({name, ".rf_wen"}, 32'(rf_wen), 32'(g.rw));
            check({name, ".dm_wen"}, 32'(dm_wen), 32'(g.dw));
            check({name, ".wdsel"}, 32'(rf_wdata_sel), 32'(g.wds));
            check({name, ".taken"}, 32'(branch_taken), 32'(g.tk));
            check({name, ".illegal"}, 32'(illegal), 32'(g.il));
            if (g.chk_alu)
                check({name, ".alu"}, alu_out, g.alu);
        end
    endtask

    task automatic check_cleared(input string name);
        check({name, ".valid"}, 32'(out_valid), 32'd0);
        check({name, ".rf_wen"}, 32'(rf_wen), 32'd0);
        check({name, ".dm_wen"}, 32'(dm_wen), 32'd0);
        check({name, ".taken"}, 32'(branch_taken), 32'd0);
        check({name, ".illegal"}, 32'(illegal), 32'd0);
        check({name, ".alu"}, alu_out, 32'd0);
        check({name, ".wsel"}, 32'(rf_wsel), 32'd0);
        check({name, ".wdsel"}, 32'(rf_wdata_sel), 32'd3);
    endtask

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] B  = 7'b1100011;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    initial begin
        exp_t e;
        rst = 1'b0;
        in_valid = 1'b0;
        instruction = 32'h0;
        pc = 32'h0;
        rs1_data = 32'h0;
        rs2_data = 32'h0;
        imm = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk);
        rst = 1'b1;

        step("add", 1, enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, R), 32'h0,
             32'h7FFFFFFF, 32'h1, 32'h0,
             mk(1, 3, 1, 0, 2'b01, 32'h80000000, 0, 0, 1));
        step("sub", 1, enc(7'h20, 5'd2, 5'd1, 3'b000, 5'd4, R), 32'h0,
             32'd5, 32'd7, 32'h0,
             mk(1, 4, 1, 0, 2'b01, 32'hFFFFFFFE, 0, 0, 1));
        step("srai", 1, enc(7'h20, 5'd4, 5'd1, 3'b101, 5'd5, I), 32'h0,
             32'h80000000, 32'h0, 32'h404,
             mk(1, 5, 1, 0, 2'b01, 32'hF8000000, 0, 0, 1));
        step("srli", 1, enc(7'h00, 5'd4, 5'd1, 3'b101, 5'd5, I), 32'h0,
             32'h80000000, 32'h0, 32'h4,
             mk(1, 5, 1, 0, 2'b01, 32'h08000000, 0, 0, 1));
        step("addi_b30", 1, enc(7'h20, 5'd0, 5'd1, 3'b000, 5'd6, I), 32'h0,
             32'd10, 32'h0, 32'h400,
             mk(1, 6, 1, 0, 2'b01, 32'h0000040A, 0, 0, 1));
        step("slti", 1, enc(7'h00, 5'd1, 5'd1, 3'b010, 5'd7, I), 32'h0,
             32'hFFFFFFFF, 32'h0, 32'h1,
             mk(1, 7, 1, 0, 2'b01, 32'h1, 0, 0, 1));
        step("sltiu", 1, enc(7'h00, 5'd1, 5'd1, 3'b011, 5'd7, I), 32'h0,
             32'hFFFFFFFF, 32'h0, 32'h1,
             mk(1, 7, 1, 0, 2'b01, 32'h0, 0, 0, 1));
        step("blt", 1, enc(7'h7F, 5'd2, 5'd1, 3'b100, 5'd0, B), 32'h80000010,
             32'hFFFFFFFF, 32'h1, 32'hFFFFFFF0,
             mk(1, 0, 0, 0, 2'b11, 32'h80000000, 1, 0, 1));
        step("bltu", 1, enc(7'h7F, 5'd2, 5'd1, 3'b110, 5'd0, B), 32'h80000010,
             32'hFFFFFFFF, 32'h1, 32'hFFFFFFF0,
             mk(1, 0, 0, 0, 2'b11, 32'h80000000, 0, 0, 1));
        step("beq", 1, enc(7'h01, 5'd2, 5'd1, 3'b000, 5'd0, B), 32'h40,
             32'd5, 32'd5, 32'h20,
             mk(1, 0, 0, 0, 2'b11, 32'h60, 1, 0, 1));
        step("bne", 1, enc(7'h01, 5'd2, 5'd1, 3'b001, 5'd0, B), 32'h40,
             32'd5, 32'd5, 32'h20,
             mk(1, 0, 0, 0, 2'b11, 32'h60, 0, 0, 1));
        step("b_f3_010", 1, enc(7'h01, 5'd2, 5'd1, 3'b010, 5'd0, B), 32'h40,
             32'd0,32'd0, 32'h20,
             mk(1, 0, 0, 0, 2'b11, 32'h60, 0, 0, 1));
        step("jalr", 1, enc(7'h00, 5'd4, 5'd2, 3'b000, 5'd1, 7'b1100111),
             32'h100, 32'h80000101, 32'h0, 32'h4,
             mk(1, 1, 1, 0, 2'b00, 32'h80000104, 1, 0, 1));
        step("jal", 1, enc(7'h00, 5'd8, 5'd0, 3'b000, 5'd1, 7'b1101111),
             32'h100, 32'h0, 32'h0, 32'h8,
             mk(1, 1, 1, 0, 2'b00, 32'h108, 1, 0, 1));
        step("lui", 1, {20'h12345, 5'd7, 7'b0110111}, 32'h200,
             32'hDEAD0000, 32'h0, 32'h12345000,
             mk(1, 7, 1, 0, 2'b01, 32'h12345000, 0, 0, 1));
        step("auipc", 1, {20'h00002, 5'd7, 7'b0010111}, 32'h1000,
             32'h0, 32'h0, 32'h2000,
             mk(1, 7, 1, 0, 2'b01, 32'h3000, 0, 0, 1));
        step("lw", 1, enc(7'h7F, 5'd28, 5'd1, 3'b010, 5'd6, LD), 32'h0,
             32'h100, 32'h0, 32'hFFFFFFFC,
             mk(1, 6, 1, 0, 2'b10, 32'hFC, 0, 0, 1));
        step("sw", 1, enc(7'h00, 5'd2, 5'd1, 3'b010, 5'd8, ST), 32'h0,
             32'h200, 32'h55, 32'h8,
             mk(1, 8, 0, 1, 2'b11, 32'h208, 0, 0, 1));
        step("addi_x0", 1, enc(7'h00, 5'd5, 5'd1, 3'b000, 5'd0, I), 32'h0,
             32'h10, 32'h0, 32'h5,
             mk(1, 0, 0, 0, 2'b01, 32'h15, 0, 0, 1));
        last = mk(1, 0, 0, 0, 2'b01, 32'h15, 0, 0, 1);
        e = last;
        e.valid = 0;
        step("idle_hold", 0, enc(7'h00, 5'd9, 5'd9, 3'b000, 5'd9, R), 32'h0,
             32'h999, 32'h111, 32'h0, e);
        step("fence", 1, enc(7'h00, 5'd0, 5'd0, 3'b000, 5'd10, 7'b0001111),
             32'h0, 32'h4, 32'h0, 32'h4,
             mk(1, 10, 0, 0, 2'b11, 32'h0, 0, 0, 0));
        step("op_7f", 1, enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd9, 7'h7F), 32'h0,
             32'h1, 32'h2, 32'h3,
             mk(1, 9, 0, 0, 2'b11, 32'h0, 0, ILL, 0));

        rst = 1'b0;
        #1;
        check_cleared("rst_async");
        in_valid = 1'b1;
        instruction = enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, R);
        rs1_data = 32'd1;
        rs2_data = 32'd2;
        @(posedge clk);
        #1;
        check_cleared("rst_held");
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_cleared("rst_idle");

        step("add_after", 1, enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd11, R), 32'h0,
             32'd3, 32'd4, 32'h0,
             mk(1, 11, 1, 0, 2'b01, 32'd7, 0, 0, 1));

        tests++;
        assert (q.size() == 0) else begin
            fails++;
            $error("FAIL queue_drain observed=%0d expected=0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
